// File: rtl/didactic_obi2apb_pkg.sv
// Shared definitions for didactic_obi2apb_bridge: FSM state encoding and timeout constants.
// The timeout constants are only used when DIDACTIC_OBI2APB_TIMEOUT_EN is defined.
package didactic_obi2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } obi2apb_state_e;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;
  localparam logic [31:0] TIMEOUT_RDATA       = 32'h0000_0000;

endpackage

// File: rtl/didactic_obi2apb_bridge.sv
// OBI responder to APB requester bridge, one outstanding transaction, one APB transfer per request.
// Optional ACCESS-phase timeout enabled by defining DIDACTIC_OBI2APB_TIMEOUT_EN.
module didactic_obi2apb_bridge
  import didactic_obi2apb_pkg::*;
#(
  parameter int unsigned OBI_AW      = 32,
  parameter int unsigned OBI_DW      = 32,
  parameter int unsigned OBI_IDW     = 1,
  parameter int unsigned APB_AW      = 12,
  parameter int unsigned APB_DW      = 32,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  obi_req_i,
  output logic                  obi_gnt_o,
  input  logic [OBI_AW-1:0]     obi_addr_i,
  input  logic                  obi_we_i,
  input  logic [OBI_DW/8-1:0]   obi_be_i,
  input  logic [OBI_DW-1:0]     obi_wdata_i,
  input  logic [OBI_IDW-1:0]    obi_aid_i,
  output logic                  obi_rvalid_o,
  input  logic                  obi_rready_i,
  output logic [OBI_DW-1:0]     obi_rdata_o,
  output logic                  obi_err_o,
  output logic [OBI_IDW-1:0]    obi_rid_o,
  output logic [APB_AW-1:0]     paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [APB_DW-1:0]     pwdata_o,
  output logic [APB_DW/8-1:0]   pstrb_o,
  input  logic [APB_DW-1:0]     prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  obi2apb_state_e          state_reg, state_next;
  logic [APB_AW-1:0]       paddr_reg;
  logic                    pwrite_reg;
  logic [APB_DW/8-1:0]     pstrb_reg;
  logic [APB_DW-1:0]       pwdata_reg;
  logic [OBI_IDW-1:0]      rid_reg;
  logic [OBI_DW-1:0]       rdata_reg;
  logic                    err_reg;
  logic                    unused_ok;

`ifdef DIDACTIC_OBI2APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;

  // Expiry on the TIMEOUT_CYC-th ACCESS cycle; a simultaneous pready_i still completes normally.
  assign timeout_hit = (state_reg == ACCESS) && !pready_i &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      cnt_reg <= '0;
    end else if (state_reg != ACCESS) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign unused_ok = ^obi_addr_i[OBI_AW-1:APB_AW];
`else
  assign unused_ok = ^{obi_addr_i[OBI_AW-1:APB_AW], TIMEOUT_CYC[0]};
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (obi_req_i) state_next = SETUP;
      SETUP:   state_next = ACCESS;
`ifdef DIDACTIC_OBI2APB_TIMEOUT_EN
      ACCESS:  if (pready_i || timeout_hit) state_next = RESP;
`else
      ACCESS:  if (pready_i) state_next = RESP;
`endif
      RESP:    if (obi_rready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rst_ni is active-high here; reset clears any in-flight transfer without a response.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_reg  <= IDLE;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pstrb_reg  <= '0;
      pwdata_reg <= '0;
      rid_reg    <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && obi_req_i) begin
        paddr_reg  <= obi_addr_i[APB_AW-1:0];
        pwrite_reg <= obi_we_i;
        pstrb_reg  <= obi_we_i ? obi_be_i : '0;
        pwdata_reg <= obi_wdata_i;
        rid_reg    <= obi_aid_i;
      end
      if (state_reg == ACCESS && pready_i) begin
        rdata_reg <= pwrite_reg ? '0 : prdata_i;
        err_reg   <= pslverr_i;
      end
`ifdef DIDACTIC_OBI2APB_TIMEOUT_EN
      else if (timeout_hit) begin
        rdata_reg <= OBI_DW'(TIMEOUT_RDATA);
        err_reg   <= 1'b1;
      end
`endif
    end
  end

  assign obi_gnt_o    = (state_reg == IDLE) && obi_req_i;
  assign obi_rvalid_o = (state_reg == RESP);
  assign obi_rdata_o  = rdata_reg;
  assign obi_err_o    = err_reg;
  assign obi_rid_o    = rid_reg;
  assign psel_o       = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable_o    = (state_reg == ACCESS);
  assign paddr_o      = paddr_reg;
  assign pwrite_o     = pwrite_reg;
  assign pwdata_o     = pwdata_reg;
  assign pstrb_o      = pstrb_reg;

endmodule

// File: tb/tb_didactic_obi2apb_bridge.sv
// Directed, table-driven bench for didactic_obi2apb_bridge, plus hand-written corner sequences.
// Timeout expectations switch on DIDACTIC_OBI2APB_TIMEOUT_EN.
module tb_didactic_obi2apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        obi_req = 1'b0, obi_gnt, obi_we = 1'b0, obi_rvalid, obi_rready = 1'b0, obi_err;
  logic [31:0] obi_addr = '0, obi_wdata = '0, obi_rdata, prdata = '0, pwdata;
  logic [3:0]  obi_be = '0, pstrb;
  logic        obi_aid = 1'b0, obi_rid;
  logic [11:0] paddr;
  logic        psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  didactic_obi2apb_bridge #(
    .OBI_AW(32), .OBI_DW(32), .OBI_IDW(1), .APB_AW(12), .APB_DW(32), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr), .obi_we_i(obi_we),
    .obi_be_i(obi_be), .obi_wdata_i(obi_wdata), .obi_aid_i(obi_aid),
    .obi_rvalid_o(obi_rvalid), .obi_rready_i(obi_rready), .obi_rdata_o(obi_rdata),
    .obi_err_o(obi_err), .obi_rid_o(obi_rid),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic [31:0] prdata;
    logic        pslverr;
    int          waits;
    int          hold;
    logic [11:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_rid;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int lat;
    obi_we = v.we; obi_addr = v.addr; obi_be = v.be; obi_wdata = v.wdata; obi_aid = v.aid;
    prdata = v.prdata; pslverr = v.pslverr; obi_req = 1'b1;
    #1;
    chk("gnt_idle", 32'(obi_gnt), 32'd1);
    chk("psel_idle", 32'(psel), 32'd0);
    tick();
    obi_req = 1'b0; obi_wdata = 32'h0; obi_addr = 32'h0; obi_be = 4'h0; obi_we = 1'b0;
    lat = 1;
    chk("psel_setup", 32'(psel), 32'd1);
    chk("penable_setup", 32'(penable), 32'd0);
    chk("paddr", 32'(paddr), 32'(v.exp_paddr));
    chk("pwrite", 32'(pwrite), 32'(v.we));
    chk("pstrb", 32'(pstrb), 32'(v.exp_pstrb));
    chk("pwdata", pwdata, v.wdata);
    chk("gnt_busy", 32'(obi_gnt), 32'd0);
    while (!obi_rvalid && lat < 200) begin
      if (lat >= 2) begin
        chk("penable_access", 32'(penable), 32'd1);
        chk("pwdata_stable", pwdata, v.wdata);
        chk("paddr_stable", 32'(paddr), 32'(v.exp_paddr));
      end
      pready = (lat >= 2 + v.waits);
      tick();
      lat++;
    end
    pready = 1'b0;
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("rvalid", 32'(obi_rvalid), 32'd1);
    chk("rdata", obi_rdata, v.exp_rdata);
    chk("err", 32'(obi_err), 32'(v.exp_err));
    chk("rid", 32'(obi_rid), 32'(v.exp_rid));
    chk("psel_resp", 32'(psel), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk("rvalid_hold", 32'(obi_rvalid), 32'd1);
      chk("rdata_hold", obi_rdata, v.exp_rdata);
      chk("err_hold", 32'(obi_err), 32'(v.exp_err));
    end
    obi_rready = 1'b1;
    tick();
    obi_rready = 1'b0;
    chk("rvalid_done", 32'(obi_rvalid), 32'd0);
    $display("txn %0d: we=%0d addr=%h rdata=%h err=%0d rid=%0d latency=%0d",
             idx, v.we, v.addr, obi_rdata, obi_err, obi_rid, lat);
  endtask

  initial begin
    logic [7:0] gnt_pat;
    logic [7:0] psel_pat;
    int lat;

    vecs[0] = '{we:1'b0, addr:32'h0000_0104, be:4'hF, wdata:32'hDEAD_BEEF, aid:1'b0,
                prdata:32'hCAFE_F00D, pslverr:1'b0, waits:0, hold:0,
                exp_paddr:12'h104, exp_pstrb:4'h0, exp_rdata:32'hCAFE_F00D, exp_err:1'b0,
                exp_rid:1'b0, exp_lat:3};
    vecs[1] = '{we:1'b1, addr:32'h0000_0010, be:4'b0011, wdata:32'h1234_5678, aid:1'b0,
                prdata:32'hFFFF_FFFF, pslverr:1'b0, waits:3, hold:0,
                exp_paddr:12'h010, exp_pstrb:4'b0011, exp_rdata:32'h0, exp_err:1'b0,
                exp_rid:1'b0, exp_lat:6};
    vecs[2] = '{we:1'b0, addr:32'h0000_0200, be:4'hF, wdata:32'h0, aid:1'b1,
                prdata:32'h55AA_55AA, pslverr:1'b1, waits:0, hold:4,
                exp_paddr:12'h200, exp_pstrb:4'h0, exp_rdata:32'h55AA_55AA, exp_err:1'b1,
                exp_rid:1'b1, exp_lat:3};
    vecs[3] = '{we:1'b0, addr:32'hFFFF_F7FC, be:4'hF, wdata:32'h0, aid:1'b0,
                prdata:32'h0BAD_C0DE, pslverr:1'b0, waits:1, hold:1,
                exp_paddr:12'h7FC, exp_pstrb:4'h0, exp_rdata:32'h0BAD_C0DE, exp_err:1'b0,
                exp_rid:1'b0, exp_lat:4};
    vecs[4] = '{we:1'b1, addr:32'h8000_0ABC, be:4'b1000, wdata:32'hA5A5_A5A5, aid:1'b1,
                prdata:32'h1357_9BDF, pslverr:1'b1, waits:0, hold:0,
                exp_paddr:12'hABC, exp_pstrb:4'b1000, exp_rdata:32'h0, exp_err:1'b1,
                exp_rid:1'b1, exp_lat:3};

    // Reset state
    tick(); tick();
    chk("rst_gnt", 32'(obi_gnt), 32'd0);
    chk("rst_rvalid", 32'(obi_rvalid), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    rst_ni = 1'b0;
    tick();
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    chk("rst_rdata", obi_rdata, 32'd0);
    chk("rst_rid", 32'(obi_rid), 32'd0);
    chk("rst_err", 32'(obi_err), 32'd0);

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

    // req held high with rready=1: next grant only after the RESP handshake cycle
    gnt_pat  = 8'b0001_0001;
    psel_pat = 8'b0110_0110;
    obi_we = 1'b0; obi_addr = 32'h0000_0040; obi_aid = 1'b0; prdata = 32'h0000_0042;
    pslverr = 1'b0; pready = 1'b1; obi_rready = 1'b1; obi_req = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("b2b_gnt_c%0d", c), 32'(obi_gnt), 32'(gnt_pat[c]));
      chk($sformatf("b2b_psel_c%0d", c), 32'(psel), 32'(psel_pat[c]));
      if (c == 7) obi_req = 1'b0;
      tick();
    end
    pready = 1'b0; obi_rready = 1'b0;
    chk("b2b_idle_psel", 32'(psel), 32'd0);
    $display("txn b2b: two back-to-back reads with req held high");

    // Reset asserted during ACCESS
    obi_addr = 32'h0000_0020; obi_we = 1'b0; obi_req = 1'b1;
    tick();
    obi_req = 1'b0;
    tick();
    chk("rstmid_penable_pre", 32'(penable), 32'd1);
    #2 rst_ni = 1'b1;
    #1;
    chk("rstmid_psel", 32'(psel), 32'd0);
    chk("rstmid_penable", 32'(penable), 32'd0);
    chk("rstmid_rvalid", 32'(obi_rvalid), 32'd0);
    tick(); tick();
    rst_ni = 1'b0;
    tick();
    chk("rstmid_no_resp", 32'(obi_rvalid), 32'd0);
    $display("txn rst: transfer dropped by reset in ACCESS");
    run_txn(5, vecs[0]);

    // ACCESS phase with pready stuck low
    obi_addr = 32'h0000_0300; obi_we = 1'b0; obi_aid = 1'b0; prdata = 32'h1111_1111;
    pslverr = 1'b0; pready = 1'b0; obi_req = 1'b1;
    tick();
    obi_req = 1'b0;
    lat = 1;
    while (!obi_rvalid && lat < 100) begin
      tick();
      lat++;
    end
`ifdef DIDACTIC_OBI2APB_TIMEOUT_EN
    chk("to_latency", 32'(lat), 32'd10);
    chk("to_rvalid", 32'(obi_rvalid), 32'd1);
    chk("to_err", 32'(obi_err), 32'd1);
    chk("to_rdata", obi_rdata, 32'd0);
    chk("to_psel", 32'(psel), 32'd0);
`else
    chk("wait_rvalid", 32'(obi_rvalid), 32'd0);
    chk("wait_psel", 32'(psel), 32'd1);
    chk("wait_penable", 32'(penable), 32'd1);
    pready = 1'b1;
    tick();
    pready = 1'b0;
    chk("wait_done_rvalid", 32'(obi_rvalid), 32'd1);
    chk("wait_done_rdata", obi_rdata, 32'h1111_1111);
`endif
    obi_rready = 1'b1;
    tick();
    obi_rready = 1'b0;
    chk("stuck_exit_rvalid", 32'(obi_rvalid), 32'd0);
    $display("txn stuck: pready held low, cycles observed=%0d", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
